// File: rtl/sa_tile_controller_pkg.sv
// Shared constants and state encoding for the systolic-array tile controller
// and its memory address arbiter.
package sa_tile_controller_pkg;

    localparam int ADDR_W           = 6;
    localparam int DATA_W           = 8;
    localparam int TILE_W           = 4;
    localparam int CNT_W            = 5;
    localparam int LOAD_CYCLES_DEF  = 18;
    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int FEAT_STRIDE_DEF  = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_F = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/sa_mem_addr_arbiter.sv
// Combinational owner select for the shared feature/weight memory: the active
// loader owns it while loading, the host only in IDLE when no start is pending.
import sa_tile_controller_pkg::*;

module sa_mem_addr_arbiter (
    input  state_e            state_i,
    input  logic              start_i,
    input  logic              host_req_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [ADDR_W-1:0] wgt_addr_i,
    input  logic [ADDR_W-1:0] feat_addr_i,
    output logic              host_gnt_o,
    output logic [ADDR_W-1:0] mem_addr_o
);

    always_comb begin
        host_gnt_o = host_req_i && (state_i == ST_IDLE) && !start_i;
        mem_addr_o = '0;
        case (state_i)
            ST_LOAD_W: mem_addr_o = wgt_addr_i;
            ST_LOAD_F: mem_addr_o = feat_addr_i;
            default:   mem_addr_o = host_gnt_o ? host_addr_i : '0;
        endcase
    end

endmodule

// File: rtl/sa_tile_controller.sv
// Sequences one systolic-array job: weight load, then feature load + drain per tile.
// Optional busy-cycle counter output perf_cycles_o when SA_TILE_PERF_CNT_EN is defined.
import sa_tile_controller_pkg::*;

module sa_tile_controller #(
    parameter int LOAD_CYCLES  = LOAD_CYCLES_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int FEAT_STRIDE  = FEAT_STRIDE_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [TILE_W-1:0] tile_cnt_i,
    input  logic [ADDR_W-1:0] feat_base_i,
    input  logic [ADDR_W-1:0] wgt_base_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic              wgt_en_o,
    output logic [ADDR_W-1:0] wgt_baseaddr_o,
    input  logic [ADDR_W-1:0] wgt_addr_i,
    output logic              feat_en_o,
    output logic [ADDR_W-1:0] feat_baseaddr_o,
    input  logic [ADDR_W-1:0] feat_addr_i,
    input  logic              host_req_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    output logic              host_gnt_o,
    output logic [ADDR_W-1:0] mem_addr_o
`ifdef SA_TILE_PERF_CNT_EN
    ,
    output logic [15:0]       perf_cycles_o
`endif
);

    localparam logic [CNT_W-1:0]  LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] STRIDE      = ADDR_W'(FEAT_STRIDE);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TILE_W-1:0]   tile_cnt_q, tile_cnt_d;
    logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
    logic [ADDR_W-1:0]   wgt_base_q, wgt_base_d;
    logic [ADDR_W-1:0]   feat_base_q, feat_base_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                wgt_en_q, wgt_en_d, feat_en_q, feat_en_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tile_cnt_q  <= '0;
            tile_idx_q  <= '0;
            wgt_base_q  <= '0;
            feat_base_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wgt_en_q    <= 1'b0;
            feat_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            tile_idx_q  <= tile_idx_d;
            wgt_base_q  <= wgt_base_d;
            feat_base_q <= feat_base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wgt_en_q    <= wgt_en_d;
            feat_en_q   <= feat_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_cnt_d  = tile_cnt_q;
        tile_idx_d  = tile_idx_q;
        wgt_base_d  = wgt_base_q;
        feat_base_d = feat_base_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (tile_cnt_i != '0) begin
                        tile_cnt_d  = tile_cnt_i;
                        tile_idx_d  = '0;
                        wgt_base_d  = wgt_base_i;
                        feat_base_d = feat_base_i;
                        cnt_d       = '0;
                        state_d     = ST_LOAD_W;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD_W: begin
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD_F;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD_F: begin
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    // Extra bit so tile_idx+1 cannot wrap when tile_cnt is 15.
                    if (({1'b0, tile_idx_q} + 5'd1) < {1'b0, tile_cnt_q}) begin
                        tile_idx_d  = tile_idx_q + 1'b1;
                        feat_base_d = feat_base_q + STRIDE;
                        state_d     = ST_LOAD_F;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up with state_q.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        wgt_en_d  = (state_d == ST_LOAD_W);
        feat_en_d = (state_d == ST_LOAD_F);
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign tile_idx_o      = tile_idx_q;
    assign wgt_en_o        = wgt_en_q;
    assign wgt_baseaddr_o  = wgt_base_q;
    assign feat_en_o       = feat_en_q;
    assign feat_baseaddr_o = feat_base_q;

    sa_mem_addr_arbiter u_arb (
        .state_i     (state_q),
        .start_i     (start_i),
        .host_req_i  (host_req_i),
        .host_addr_i (host_addr_i),
        .wgt_addr_i  (wgt_addr_i),
        .feat_addr_i (feat_addr_i),
        .host_gnt_o  (host_gnt_o),
        .mem_addr_o  (mem_addr_o)
    );

`ifdef SA_TILE_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    // The accepting cycle counts as the first busy cycle, hence the reload to 1.
    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_IDLE) && start_i) begin
            perf_d = 16'd1;
        end else if (busy_q && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_sa_tile_controller.sv
// Randomized self-checking bench for sa_tile_controller against a timeline model
// of the job schedule (weight run, per-tile feature run + drain, done).
module tb_sa_tile_controller;

    localparam int L      = 18;
    localparam int D      = 4;
    localparam int STRIDE = 9;
    localparam int P      = L + D;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] tile_cnt;
    logic [5:0] feat_base, wgt_base;
    logic       busy, done, wgt_en, feat_en, host_req, host_gnt;
    logic [3:0] tile_idx;
    logic [5:0] wgt_baseaddr, wgt_addr, feat_baseaddr, feat_addr, host_addr, mem_addr;
`ifdef SA_TILE_PERF_CNT_EN
    logic [15:0] perf_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0] last_idx;
    logic [5:0] last_fb, last_wb;

    always #5 clk = ~clk;

    sa_tile_controller dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .tile_cnt_i      (tile_cnt),
        .feat_base_i     (feat_base),
        .wgt_base_i      (wgt_base),
        .busy_o          (busy),
        .done_o          (done),
        .tile_idx_o      (tile_idx),
        .wgt_en_o        (wgt_en),
        .wgt_baseaddr_o  (wgt_baseaddr),
        .wgt_addr_i      (wgt_addr),
        .feat_en_o       (feat_en),
        .feat_baseaddr_o (feat_baseaddr),
        .feat_addr_i     (feat_addr),
        .host_req_i      (host_req),
        .host_addr_i     (host_addr),
        .host_gnt_o      (host_gnt),
        .mem_addr_o      (mem_addr)
`ifdef SA_TILE_PERF_CNT_EN
        ,
        .perf_cycles_o   (perf_cycles)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; start = 0; tile_cnt = 0; feat_base = 0; wgt_base = 0;
        host_req = 0; host_addr = 0; wgt_addr = 6'h15; feat_addr = 6'h2B;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, wgt_en, feat_en, tile_idx, wgt_baseaddr, feat_baseaddr, host_gnt, mem_addr} !== 27'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b w=%b f=%b idx=%0d wb=%h fb=%h gnt=%b mem=%h want all 0",
                     busy, done, wgt_en, feat_en, tile_idx, wgt_baseaddr, feat_baseaddr, host_gnt, mem_addr);
        end
`ifdef SA_TILE_PERF_CNT_EN
        checks++;
        if (perf_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_perf got %0d want 0", perf_cycles);
        end
`endif
        rst_n = 1'b1;
        last_idx = 0; last_fb = 0; last_wb = 0;
        @(posedge clk); #1;
        host_req = 1; host_addr = 6'h2A;
        #1;
        checks++;
        if ({busy, host_gnt, mem_addr} !== {1'b0, 1'b1, 6'h2A}) begin
            failures++;
            $display("FAIL idle_host got busy=%b gnt=%b mem=%h want 0 1 2a", busy, host_gnt, mem_addr);
        end
        host_req = 0;
        $display("reset: done");
    endtask

    task automatic test_job(input int t, input logic [5:0] fb, input logic [5:0] wb, input bit noise);
        int done_k, ti, tile, r;
        logic e_busy, e_done, e_w, e_f, e_gnt;
        logic [3:0] e_idx;
        logic [5:0] e_fb, e_wb, e_mem;
        int errs;
        errs = 0;
        done_k = (t == 0) ? 0 : L + t * P;
        @(posedge clk); #1;
        start = 1; tile_cnt = 4'(t); feat_base = fb; wgt_base = wb;
        host_req = 1'($urandom_range(0, 1)); host_addr = 6'($urandom);
        #1;
        checks++;
        if (host_gnt !== 1'b0) begin
            $display("FAIL start_tie_gnt got %b want 0", host_gnt); errs++; failures++;
        end
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k <= done_k + 2; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (noise && k <= done_k) begin
                start = 1'($urandom_range(0, 1)); tile_cnt = 4'($urandom);
                feat_base = 6'($urandom); wgt_base = 6'($urandom);
            end else begin
                start = 0;
            end
            wgt_addr = 6'($urandom); feat_addr = 6'($urandom);
            host_req = 1'($urandom_range(0, 1)); host_addr = 6'($urandom);
            #1;
            e_busy = (k <= done_k);
            e_done = (k == done_k);
            e_w    = (t != 0) && (k < L);
            e_f    = 1'b0;
            ti     = 0;
            if (t != 0 && k >= L && k < done_k) begin
                tile = (k - L) / P; r = (k - L) % P;
                e_f = (r < L); ti = tile;
            end else if (t != 0 && k >= done_k) begin
                ti = t - 1;
            end
            if (t == 0) begin
                e_idx = last_idx; e_fb = last_fb; e_wb = last_wb;
            end else begin
                e_idx = 4'(ti); e_fb = 6'((int'(fb) + STRIDE * ti) % 64); e_wb = wb;
            end
            e_gnt = host_req && !e_busy && !start;
            e_mem = e_w ? wgt_addr : e_f ? feat_addr : e_gnt ? host_addr : 6'd0;
            checks++;
            if ({busy, done, wgt_en, feat_en, tile_idx, wgt_baseaddr, feat_baseaddr, host_gnt, mem_addr}
                !== {e_busy, e_done, e_w, e_f, e_idx, e_wb, e_fb, e_gnt, e_mem}) begin
                errs++;
                failures++;
                $display("FAIL job_t%0d_k%0d got busy=%b done=%b w=%b f=%b idx=%0d wb=%h fb=%h gnt=%b mem=%h want %b %b %b %b %0d %h %h %b %h",
                         t, k, busy, done, wgt_en, feat_en, tile_idx, wgt_baseaddr, feat_baseaddr, host_gnt, mem_addr,
                         e_busy, e_done, e_w, e_f, e_idx, e_wb, e_fb, e_gnt, e_mem);
            end
`ifdef SA_TILE_PERF_CNT_EN
            checks++;
            if (perf_cycles !== 16'(((k < done_k + 1) ? k : done_k + 1) + 1)) begin
                errs++;
                failures++;
                $display("FAIL perf_t%0d_k%0d got %0d want %0d", t, k, perf_cycles,
                         ((k < done_k + 1) ? k : done_k + 1) + 1);
            end
`endif
        end
        host_req = 0;
        if (t != 0) begin
            last_idx = 4'(t - 1); last_fb = 6'((int'(fb) + STRIDE * (t - 1)) % 64); last_wb = wb;
        end
        $display("job: tiles=%0d fb=%h wb=%h noise=%0d done_at=%0d errors=%0d", t, fb, wb, noise, done_k, errs);
    endtask

    task automatic test_host_arbitration();
        int k;
        bit seen;
        @(posedge clk); #1;
        start = 1; tile_cnt = 1; feat_base = 6'h30; wgt_base = 6'h07;
        host_req = 1; host_addr = 6'h11;
        #1;
        checks++;
        if (host_gnt !== 1'b0) begin
            failures++;
            $display("FAIL host_tie_gnt got %b want 0", host_gnt);
        end
        @(posedge clk); #1;
        start = 0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL host_tie_start got busy=%b want 1", busy);
        end
        repeat (25) @(posedge clk);
        #1;
        feat_addr = 6'($urandom);
        #1;
        checks++;
        if ({feat_en, host_gnt, mem_addr} !== {1'b1, 1'b0, feat_addr}) begin
            failures++;
            $display("FAIL host_held_off got f=%b gnt=%b mem=%h want 1 0 %h", feat_en, host_gnt, mem_addr, feat_addr);
        end
        k = 25; seen = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(posedge clk); #1;
            k++;
            if (done) seen = 1;
        end
        checks++;
        if (!seen || k != L + P) begin
            failures++;
            $display("FAIL host_job_done got seen=%0d at=%0d want 1 at %0d", seen, k, L + P);
        end
        @(posedge clk); #2;
        checks++;
        if ({busy, host_gnt, mem_addr} !== {1'b0, 1'b1, 6'h11}) begin
            failures++;
            $display("FAIL host_grant_idle got busy=%b gnt=%b mem=%h want 0 1 11", busy, host_gnt, mem_addr);
        end
        host_req = 0;
        last_idx = 0; last_fb = 6'h30; last_wb = 6'h07;
        $display("host_arbitration: done");
    endtask

    task automatic test_abort();
        logic [5:0] fb;
        fb = 6'($urandom);
        @(posedge clk); #1;
        start = 1; tile_cnt = 3; feat_base = fb; wgt_base = 6'($urandom); host_req = 0;
        @(posedge clk); #1;
        start = 0;
        repeat (L + P + 5) @(posedge clk);
        #1;
        checks++;
        if ({feat_en, tile_idx, feat_baseaddr} !== {1'b1, 4'd1, 6'((int'(fb) + STRIDE) % 64)}) begin
            failures++;
            $display("FAIL abort_pre got f=%b idx=%0d fb=%h want 1 1 %h", feat_en, tile_idx, feat_baseaddr,
                     6'((int'(fb) + STRIDE) % 64));
        end
        rst_n = 0;
        #1;
        checks++;
        if ({busy, done, wgt_en, feat_en, tile_idx, wgt_baseaddr, feat_baseaddr} !== 20'd0) begin
            failures++;
            $display("FAIL abort_async got busy=%b done=%b w=%b f=%b idx=%0d wb=%h fb=%h want all 0",
                     busy, done, wgt_en, feat_en, tile_idx, wgt_baseaddr, feat_baseaddr);
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, done} !== 2'b00) begin
                failures++;
                $display("FAIL abort_hold_%0d got busy=%b done=%b want 0 0", n, busy, done);
            end
        end
        rst_n = 1;
        last_idx = 0; last_fb = 0; last_wb = 0;
        $display("abort: done");
    endtask

    initial begin
        test_reset();
        test_job(1, 6'h00, 6'h20, 0);
        test_job(3, 6'h3C, 6'h01, 0);
        test_job(0, 6'h12, 6'h34, 0);
        test_host_arbitration();
        test_abort();
        test_job(2, 6'($urandom), 6'($urandom), 0);
        test_job(15, 6'($urandom), 6'($urandom), 1);
        for (int i = 0; i < 6; i++)
            test_job($urandom_range(0, 5), 6'($urandom), 6'($urandom), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
